// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one unified memory bus between the CPU's
// instruction-fetch port and data port. Round-robin on ties, waitrequest
// handshake on both sides, and a watchdog that aborts accesses the memory
// never completes.
//
// Handshake (both requester ports): a request (instr_read, or
// data_read/data_write) is held until the port's waitrequest is low. That
// waitrequest is low for exactly one cycle, the RESP cycle, and the
// readdata is valid there and held afterwards. On the memory side a strobe
// (mem_read/mem_write) completes in the first cycle it is high with
// mem_waitrequest low.
module mips_mem_arbiter #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    // instruction-fetch port
    input  logic        instr_read,
    input  logic [31:0] instr_address,
    output logic        instr_waitrequest,
    output logic [31:0] instr_readdata,
    // data port
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic        data_waitrequest,
    output logic [31:0] data_readdata,
    // unified memory bus
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    // status and debug visibility
    output logic        bus_error,
    output logic [2:0]  dbg_state,
    output logic        dbg_last_grant
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT_I = 3'd1;
    localparam logic [2:0] S_GRANT_D = 3'd2;
    localparam logic [2:0] S_RESP_I  = 3'd3;
    localparam logic [2:0] S_RESP_D  = 3'd4;

    localparam logic LG_INSTR = 1'b0;
    localparam logic LG_DATA  = 1'b1;

    logic        instr_req;
    logic        data_req;

    logic [2:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic [3:0]  mem_byteenable_q, mem_byteenable_d;
    logic [31:0] instr_readdata_q, instr_readdata_d;
    logic [31:0] data_readdata_q, data_readdata_d;
    logic        bus_error_q, bus_error_d;

    logic        grant_i;
    logic        grant_d;
    logic        wd_expire;
    logic        access_end;
    logic [31:0] wd_next;
    logic [31:0] end_data;

    assign instr_req = instr_read;
    assign data_req  = data_read | data_write;

    assign wd_next   = wd_cnt_q + 32'd1;
    // The count reaches the limit in the cycle it would be incremented to it,
    // so the strobe is high for exactly WAIT_LIMIT stalled cycles.
    assign wd_expire = (WAIT_LIMIT != 0) && mem_waitrequest && (wd_next == WAIT_LIMIT);
    assign access_end = !mem_waitrequest || wd_expire;
    assign end_data   = wd_expire ? ERR_DATA : mem_readdata;

    // Next-state logic: arbitration, access completion/abort and bus loading
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        wd_cnt_d         = wd_cnt_q;
        mem_address_d    = mem_address_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = mem_byteenable_q;
        instr_readdata_d = instr_readdata_q;
        data_readdata_d  = data_readdata_q;
        bus_error_d      = bus_error_q;
        grant_i          = 1'b0;
        grant_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_req && (!data_req || last_grant_q == LG_DATA)) begin
                    grant_i = 1'b1;
                end else if (data_req) begin
                    grant_d = 1'b1;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (access_end) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (wd_expire) begin
                        bus_error_d = 1'b1;
                    end
                    if (state_q == S_GRANT_I) begin
                        instr_readdata_d = end_data;
                        state_d          = S_RESP_I;
                    end else begin
                        // a write leaves the data readdata untouched
                        if (mem_read_q) begin
                            data_readdata_d = end_data;
                        end
                        state_d = S_RESP_D;
                    end
                end else begin
                    wd_cnt_d = wd_next;
                end
            end
            // The responding port's own request this cycle is the one being
            // completed, so only the other port can be granted back-to-back.
            S_RESP_I: begin
                if (data_req) begin
                    grant_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESP_D: begin
                if (instr_req) begin
                    grant_i = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Fetches are always full-word reads; write data is left as it was.
        if (grant_i) begin
            state_d          = S_GRANT_I;
            last_grant_d     = LG_INSTR;
            wd_cnt_d         = 32'd0;
            mem_address_d    = instr_address;
            mem_read_d       = 1'b1;
            mem_write_d      = 1'b0;
            mem_byteenable_d = 4'hF;
        end
        // Write wins when both data strobes are high.
        if (grant_d) begin
            state_d          = S_GRANT_D;
            last_grant_d     = LG_DATA;
            wd_cnt_d         = 32'd0;
            mem_address_d    = data_address;
            mem_read_d       = !data_write;
            mem_write_d      = data_write;
            mem_writedata_d  = data_writedata;
            mem_byteenable_d = data_byteenable;
        end
    end

    // State registers; reset low aborts any access and drops the strobes at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            last_grant_q     <= LG_DATA;
            wd_cnt_q         <= 32'd0;
            mem_address_q    <= 32'd0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= 32'd0;
            mem_byteenable_q <= 4'b0000;
            instr_readdata_q <= 32'd0;
            data_readdata_q  <= 32'd0;
            bus_error_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            wd_cnt_q         <= wd_cnt_d;
            mem_address_q    <= mem_address_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_byteenable_q <= mem_byteenable_d;
            instr_readdata_q <= instr_readdata_d;
            data_readdata_q  <= data_readdata_d;
            bus_error_q      <= bus_error_d;
        end
    end

    assign instr_waitrequest = instr_req & (state_q != S_RESP_I);
    assign data_waitrequest  = data_req & (state_q != S_RESP_D);

    assign instr_readdata = instr_readdata_q;
    assign data_readdata  = data_readdata_q;
    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = mem_byteenable_q;
    assign bus_error      = bus_error_q;
    assign dbg_state      = state_q;
    assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: a memory responder with programmable stall,
// per-port drivers with expected-readdata queues, a table of single accesses
// on an idle bus, and hand-written sequences for ties, contention, the
// watchdog and reset in mid-access.
module tb_mips_mem_arbiter;

    localparam int unsigned WLIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read;
    logic [31:0] instr_address;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic        data_waitrequest;
    logic [31:0] data_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = 32'd0;
    logic        bus_error;
    logic [2:0]  dbg_state;
    logic        dbg_last_grant;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] d_last_exp = 32'd0;

    // memory responder configuration and record of the last bus access
    int          cfg_waits = 0;
    bit          cfg_stuck = 1'b0;
    logic [31:0] mem_arr [logic [31:0]];
    logic        strobe_prev = 1'b0;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [5:0]  cap_ctl;
    int          wait_left = 0;
    int          n_str = 0;
    int          rec_strobes = 0;
    logic [31:0] rec_addr = 32'd0;
    logic [3:0]  rec_be = 4'd0;
    logic        rec_wr = 1'b0;

    typedef struct {
        bit          is_d;
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    mips_mem_arbiter #(
        .WAIT_LIMIT (WLIM),
        .ERR_DATA   (32'hDEADBEEF)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .instr_read        (instr_read),
        .instr_address     (instr_address),
        .instr_waitrequest (instr_waitrequest),
        .instr_readdata    (instr_readdata),
        .data_read         (data_read),
        .data_write        (data_write),
        .data_address      (data_address),
        .data_writedata    (data_writedata),
        .data_byteenable   (data_byteenable),
        .data_waitrequest  (data_waitrequest),
        .data_readdata     (data_readdata),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_byteenable    (mem_byteenable),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .bus_error         (bus_error),
        .dbg_state         (dbg_state),
        .dbg_last_grant    (dbg_last_grant)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2402_0005;
        if (mem_arr.exists(a)) return mem_arr[a];
        return default_word(a);
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // memory responder: stalls each access cfg_waits cycles (forever when
    // cfg_stuck), serves reads from the model, applies writes by byte lane,
    // and checks the bus stays stable while a strobe is held
    always @(negedge clk) begin
        logic        strobe;
        logic [31:0] w;
        strobe = mem_read | mem_write;
        if (strobe) begin
            if (!strobe_prev) begin
                cap_addr  = mem_address;
                cap_wdata = mem_writedata;
                cap_ctl   = {mem_byteenable, mem_read, mem_write};
                wait_left = cfg_waits;
                n_str     = 0;
            end else begin
                check32("hold_addr", mem_address, cap_addr);
                check32("hold_wdata", mem_writedata, cap_wdata);
                check_int("hold_ctl", int'({mem_byteenable, mem_read, mem_write}), int'(cap_ctl));
            end
            n_str++;
            if (cfg_stuck || wait_left > 0) begin
                mem_waitrequest = 1'b1;
                if (wait_left > 0) wait_left--;
            end else begin
                mem_waitrequest = 1'b0;
                mem_readdata    = rd_word(mem_address);
                if (mem_write) begin
                    w = rd_word(mem_address);
                    for (int b = 0; b < 4; b++) begin
                        if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
                    end
                    mem_arr[mem_address] = w;
                end
            end
        end else begin
            mem_waitrequest = 1'b0;
            if (strobe_prev) begin
                rec_addr    = cap_addr;
                rec_be      = cap_ctl[5:2];
                rec_wr      = cap_ctl[0];
                rec_strobes = n_str;
            end
        end
        strobe_prev = strobe;
    end

    // wait at negedges for the port's completion cycle, bounded
    task automatic wait_port(input bit is_d, output int done_cyc);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        done_cyc = -1;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (is_d ? !data_waitrequest : !instr_waitrequest) begin
                got = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no completion within %0d cycles", is_d ? "data" : "instr", n);
        end
    endtask

    // drive one fetch from posedge+1; completes and drops the request
    task automatic instr_access(input logic [31:0] addr, input logic [31:0] exp,
                                input int exp_lat, output int done);
        int st;
        logic [31:0] e;
        instr_read    = 1'b1;
        instr_address = addr;
        exp_i_q.push_back(exp);
        st = cyc;
        wait_port(1'b0, done);
        e = exp_i_q.pop_front();
        check32("i_rdata", instr_readdata, e);
        if (exp_lat >= 0) check_int("i_latency", done - st, exp_lat);
        @(posedge clk);
        #1;
        instr_read = 1'b0;
    endtask

    // drive one data access; a write expects readdata to stay as it was
    task automatic data_access(input bit wr, input bit rd, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] exp_rd, input int exp_lat, output int done);
        int st;
        logic [31:0] e;
        data_write      = wr;
        data_read       = rd;
        data_address    = addr;
        data_writedata  = wdata;
        data_byteenable = be;
        e = wr ? d_last_exp : exp_rd;
        exp_d_q.push_back(e);
        d_last_exp = e;
        st = cyc;
        wait_port(1'b1, done);
        e = exp_d_q.pop_front();
        check32("d_rdata", data_readdata, e);
        if (exp_lat >= 0) check_int("d_latency", done - st, exp_lat);
        @(posedge clk);
        #1;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    // global time bound
    initial begin
        #400000;
        errors++;
        $display("FAIL global_timeout: bench did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int done_a, done_b, c0;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 32'h0,         4'hF, 0, 32'h2402_0005,            2};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'h3, 3, 32'h0,                    5};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0,         4'hF, 0, 32'h5A5A_5678,            2};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'hF, 1, 32'h0,                    3};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0,         4'hF, 2, 32'hCAFE_F00D,            4};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0,         4'hF, 1, default_word(32'h3000),   3};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0,         4'h5, 0, default_word(32'h0400),   2};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'hAABB_CCDD, 4'hC, 0, 32'h0,                    2};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h0000_0404, 32'h0,         4'hF, 0, 32'hAABB_5E5E,            2};

        // reset state, with a fetch request held so its waitrequest follows it
        reset           = 1'b0;
        instr_read      = 1'b1;
        instr_address   = 32'h0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_address    = 32'h0;
        data_writedata  = 32'h0;
        data_byteenable = 4'h0;
        repeat (3) @(negedge clk);
        check32("rst_mem_address", mem_address, 32'h0);
        check32("rst_mem_writedata", mem_writedata, 32'h0);
        check_int("rst_mem_byteenable", int'(mem_byteenable), 0);
        check_int("rst_mem_strobes", int'({mem_read, mem_write}), 0);
        check_int("rst_bus_error", int'(bus_error), 0);
        check32("rst_instr_readdata", instr_readdata, 32'h0);
        check32("rst_data_readdata", data_readdata, 32'h0);
        check_int("rst_state", int'(dbg_state), 0);
        check_int("rst_last_grant", int'(dbg_last_grant), 1);
        check_int("rst_instr_wait", int'(instr_waitrequest), 1);
        check_int("rst_data_wait", int'(data_waitrequest), 0);
        instr_read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // tie on first request: instruction first, data back-to-back
        cfg_waits = 0;
        fork
            instr_access(32'h0000_1000, default_word(32'h1000), 2, done_a);
            data_access(1'b0, 1'b1, 32'h0000_2000, 32'h0, 4'hF, default_word(32'h2000), 4, done_b);
        join
        check_int("tie_last_grant", int'(dbg_last_grant), 1);

        // single accesses on an idle bus
        for (int k = 0; k < 9; k++) begin
            cfg_waits = vecs[k].waits;
            if (vecs[k].is_d) begin
                data_access(vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wdata, vecs[k].be,
                            vecs[k].exp_rd, vecs[k].exp_lat, done_a);
                check_int("vec_bus_be", int'(rec_be), int'(vecs[k].be));
            end else begin
                instr_access(vecs[k].addr, vecs[k].exp_rd, vecs[k].exp_lat, done_a);
                check32("vec_data_untouched", data_readdata, d_last_exp);
            end
            check32("vec_bus_addr", rec_addr, vecs[k].addr);
            check_int("vec_bus_wr", int'(rec_wr), int'(vecs[k].is_d & vecs[k].wr));
            check_int("vec_bus_strobes", rec_strobes, vecs[k].waits + 1);
        end

        // same-port back-to-back fetches pay one IDLE cycle
        cfg_waits = 0;
        instr_access(32'h0000_0600, default_word(32'h0600), 2, done_a);
        instr_access(32'h0000_0604, default_word(32'h0604), 2, done_b);
        check_int("same_port_gap", done_b - done_a, 3);
        check_int("pre_cont_last_grant", int'(dbg_last_grant), 0);

        // sustained contention: strict D/I alternation, a completion every 2 cycles
        c0 = cyc;
        fork
            begin
                int dd;
                for (int k = 0; k < 4; k++) begin
                    data_access(1'b0, 1'b1, 32'h700 + 32'(4 * k), 32'h0, 4'hF,
                                default_word(32'h700 + 32'(4 * k)), -1, dd);
                    check_int("cont_data_cycle", dd - c0, 2 + 4 * k);
                end
            end
            begin
                int di;
                for (int k = 0; k < 4; k++) begin
                    instr_access(32'h800 + 32'(4 * k), default_word(32'h800 + 32'(4 * k)), -1, di);
                    check_int("cont_instr_cycle", di - c0, 4 + 4 * k);
                end
            end
        join

        // watchdog: stuck memory aborts a data read after WLIM strobe cycles
        cfg_stuck = 1'b1;
        data_access(1'b0, 1'b1, 32'h0000_0500, 32'h0, 4'hF, 32'hDEAD_BEEF, int'(WLIM) + 1, done_a);
        check_int("wd_strobes", rec_strobes, int'(WLIM));
        check_int("wd_bus_error", int'(bus_error), 1);
        cfg_stuck = 1'b0;
        instr_access(32'h0000_0900, default_word(32'h0900), 2, done_a);
        check_int("wd_error_sticky_1", int'(bus_error), 1);
        data_access(1'b0, 1'b1, 32'h0000_0904, 32'h0, 4'hF, default_word(32'h0904), 2, done_a);
        check_int("wd_error_sticky_2", int'(bus_error), 1);

        // reset pulled low during GRANT_D with the request held throughout
        cfg_stuck       = 1'b1;
        data_read       = 1'b1;
        data_write      = 1'b0;
        data_address    = 32'h0000_0A00;
        data_byteenable = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check_int("rstmid_mem_read_before", int'(mem_read), 1);
        check_int("rstmid_state_before", int'(dbg_state), 2);
        #2;
        reset = 1'b0;
        #1;
        check_int("rstmid_mem_read_async", int'(mem_read), 0);
        check_int("rstmid_state", int'(dbg_state), 0);
        check_int("rstmid_data_wait", int'(data_waitrequest), 1);
        check_int("rstmid_bus_error", int'(bus_error), 0);
        check32("rstmid_data_readdata", data_readdata, 32'h0);
        d_last_exp = 32'h0;
        cfg_stuck  = 1'b0;
        @(negedge clk);
        check_int("rstmid_data_wait_held", int'(data_waitrequest), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        data_access(1'b0, 1'b1, 32'h0000_0A00, 32'h0, 4'hF, default_word(32'h0A00), 2, done_a);
        check_int("rstmid_after_state", int'(dbg_state), 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
